ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, setting the operand and HI/LO width; legal values are 8 to 64, even.
REQ-002 The block SHALL have port clk, input, 1 bit: the only clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start_i, input, 1 bit: operation request.
REQ-005 The block SHALL have port op_i, input, 3 bits: operation code.
- 000 MULT, 001 MULTU, 010 DIV, 011 DIVU.
- 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
REQ-006 The block SHALL have ports opa_i and opb_i, inputs, DATA_W bits each: rs and rt operands.
REQ-007 The block SHALL have ports hi_i and lo_i, inputs, DATA_W bits each: current HI/LO, already forwarded, used only as the accumulator base.
REQ-008 The block SHALL have port annul_i, input, 1 bit: flush, which aborts any in-flight operation.
REQ-009 The block SHALL have port busy_o, output, 1 bit: high while an operation is in flight.
REQ-010 The block SHALL have ports done_o and whilo_o, outputs, 1 bit each: single-cycle result-valid strobe and HI/LO write enable.
REQ-011 The block SHALL have ports hi_o and lo_o, outputs, DATA_W bits each: result.
REQ-012 The block SHALL have port dz_o, output, 1 bit: divide-by-zero flag, valid with done_o.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DIV and DONE.
- busy_o=1 in MUL and DIV only.
- done_o=whilo_o=1 in DONE only.
REQ-014 A start SHALL be accepted only in IDLE or DONE with annul_i=0; operands, op_i, hi_i and lo_i are captured on that edge.
REQ-015 Start requests SHALL be ignored while busy_o=1.
REQ-016 Multiply ops SHALL transition accept -> MUL -> DONE.
- The 2*DATA_W-bit product is registered in MUL.
- done_o is asserted 2 cycles after the accept edge.
REQ-017 Product signedness SHALL be: signed for MULT/MADD/MSUB; unsigned for MULTU/MADDU/MSUBU.
REQ-018 MADD(U) SHALL give {hi_o,lo_o} = {hi,lo} + product, and MSUB(U) SHALL give {hi,lo} - product, both modulo 2^(2*DATA_W), with no overflow flag.
REQ-019 Division SHALL be restoring radix-2, one quotient bit per cycle, in DIV for exactly DATA_W cycles.
- done_o is asserted DATA_W+1 cycles after the accept edge.
REQ-020 DIV SHALL operate on magnitudes.
- Quotient is negated when operand signs differ.
- Remainder takes the sign of the dividend.
- lo_o = quotient, hi_o = remainder.
REQ-021 For DIV or DIVU with opb_i=0, the FSM SHALL go from accept straight to DONE (done_o 1 cycle after accept) with lo_o all ones, hi_o = opa_i and dz_o = 1; dz_o SHALL be 0 otherwise.
REQ-022 Signed DIV of the most-negative value by -1 SHALL give lo_o = most-negative value and hi_o = 0.
REQ-023 hi_o, lo_o and dz_o SHALL hold their last result until the next DONE.
REQ-024 DONE SHALL last exactly one cycle.
- It returns to IDLE, or directly to MUL or DIV on a back-to-back accept.
REQ-025 annul_i=1 in MUL or DIV SHALL force IDLE on the next edge, with no done_o and result outputs unchanged; annul_i=1 in IDLE or DONE SHALL block acceptance.
REQ-026 done_o and whilo_o SHALL never be asserted in the same cycle as busy_o.

Reset
REQ-027 While rst=1, the FSM SHALL be held in IDLE.
- busy_o, done_o, whilo_o and dz_o are 0.
- hi_o, lo_o and all internal datapath registers are 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation, and no done_o SHALL follow.

Configuration
REQ-029 When macro EX_MULDIV_MACC_EN is defined, the MADD/MADDU/MSUB/MSUBU ops and the accumulator path SHALL be implemented.
REQ-030 When EX_MULDIV_MACC_EN is undefined:
- op_i codes 1xx are not accepted: no busy_o, no done_o, outputs unchanged.
- hi_i and lo_i are unused.

Verification
REQ-031 With DATA_W=32, MULT 0xFFFFFFFE x 0x00000003 SHALL give, 2 cycles after accept: done_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA; MULTU with the same operands SHALL give hi_o=0x00000002, lo_o=0xFFFFFFFA.
REQ-032 DIV 0xFFFFFFF9 / 0x00000002 SHALL give: busy_o for 32 cycles, done_o at accept+33, lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, dz_o=0.
REQ-033 DIVU 0x00001234 / 0 SHALL give done_o at accept+1, dz_o=1, lo_o=0xFFFFFFFF, hi_o=0x00001234.
REQ-034 With the macro defined:
- MADD with hi_i=0, lo_i=0xFFFFFFFF, operands 1 x 1 SHALL give hi_o=0x00000001, lo_o=0x00000000.
- MSUB with hi_i=lo_i=0, operands 1 x 1 SHALL give hi_o=lo_o=0xFFFFFFFF.
- With the macro undefined, both SHALL produce no busy_o and no done_o.
REQ-035 Abort and restart SHALL behave as follows.
- annul_i on cycle 10 of DIV: busy_o=0 next cycle, no done_o.
- An immediate MULTU 5 x 7 SHALL then give lo_o=0x23 at accept+2.
- rst pulsed mid-DIV: all outputs 0 immediately, no later done_o.
REQ-036 A start asserted during a MUL operation SHALL be ignored.
- A second start in the DONE cycle SHALL be accepted.
- The results of both operations SHALL come out in order.

Source files
------------

// File: rtl/ex_muldiv.sv
// Purpose: HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, plus MADD/MSUB family when built with it).
// Latency: multiply 2 cycles from accept, divide DATA_W+1 cycles, divide-by-zero 1 cycle.
// Backpressure: one operation at a time; start_i is ignored while busy_o=1; annul_i aborts the operation in flight.
//
// Build option: define EX_MULDIV_MACC_EN to implement MADD/MADDU/MSUB/MSUBU
// and the {hi_i,lo_i} accumulator path. Without it, op codes 1xx are never accepted.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start_i, op_i         request and op code (000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                         100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU)
//   opa_i, opb_i          rs / rt operands
//   hi_i, lo_i            forwarded HI/LO, accumulator base only
//   annul_i               flush: aborts the operation in flight, blocks acceptance
//   busy_o                operation in flight (MUL or DIV state)
//   done_o, whilo_o       one-cycle result strobe and HI/LO write enable
//   hi_o, lo_o, dz_o      result (held until the next completion), divide-by-zero flag
module ex_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              annul_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              dz_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int PW    = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state;
    // a_q holds the multiplicand, or the dividend magnitude that is shifted out
    // MSB-first while quotient bits shift in at the bottom.
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] rem_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              uns_q;
    logic              qneg_q;
    logic              rneg_q;
`ifdef EX_MULDIV_MACC_EN
    logic              macc_q;
    logic              sub_q;
    logic [PW-1:0]     acc_q;
`endif

    // ---------------- accept decode ----------------
    logic              op_ok;
    logic              accept;
    logic              op_div;
    logic              sa;
    logic              sb;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;

`ifdef EX_MULDIV_MACC_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~op_i[2];
    logic unused_acc_in;
    assign unused_acc_in = ^{hi_i, lo_i};
`endif

    assign accept = start_i & ~annul_i & op_ok & ((state == IDLE) || (state == DONE));
    assign op_div = ~op_i[2] & op_i[1];
    assign sa     = ~op_i[0] & opa_i[DATA_W-1];
    assign sb     = ~op_i[0] & opb_i[DATA_W-1];
    // Two's-complement negation of the most-negative value yields the same bit
    // pattern, which read as unsigned is the correct magnitude.
    assign a_mag  = sa ? (~opa_i + 1'b1) : opa_i;
    assign b_mag  = sb ? (~opb_i + 1'b1) : opb_i;

    // ---------------- multiplier ----------------
    // Extending both operands to 2*DATA_W bits makes one unsigned multiply give
    // the correct low 2*DATA_W product bits for both signed and unsigned ops.
    logic [PW-1:0] a_wide;
    logic [PW-1:0] b_wide;
    logic [PW-1:0] prod;
    logic [PW-1:0] mul_res;

    assign a_wide = {{DATA_W{~uns_q & a_q[DATA_W-1]}}, a_q};
    assign b_wide = {{DATA_W{~uns_q & b_q[DATA_W-1]}}, b_q};
    assign prod   = a_wide * b_wide;

`ifdef EX_MULDIV_MACC_EN
    assign mul_res = ~macc_q ? prod : (sub_q ? (acc_q - prod) : (acc_q + prod));
`else
    assign mul_res = prod;
`endif

    // ---------------- restoring divider step ----------------
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   rem_diff;
    logic              ge;
    logic [DATA_W-1:0] rem_nx;
    logic [DATA_W-1:0] quot_nx;
    logic [DATA_W-1:0] quot_fix;
    logic [DATA_W-1:0] rem_fix;

    assign rem_sh   = {rem_q, a_q[DATA_W-1]};
    assign rem_diff = rem_sh - {1'b0, b_q};
    // rem_q < b_q always holds, so the top bit of the difference is a clean borrow.
    assign ge       = ~rem_diff[DATA_W];
    assign rem_nx   = ge ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    assign quot_nx  = {a_q[DATA_W-2:0], ge};
    assign quot_fix = qneg_q ? (~quot_nx + 1'b1) : quot_nx;
    assign rem_fix  = rneg_q ? (~rem_nx + 1'b1) : rem_nx;

    // ---------------- FSM with registered outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            uns_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`ifdef EX_MULDIV_MACC_EN
            macc_q  <= 1'b0;
            sub_q   <= 1'b0;
            acc_q   <= '0;
`endif
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            whilo_o <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
            dz_o    <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            whilo_o <= 1'b0;
            case (state)
                MUL: begin
                    busy_o <= 1'b0;
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        state   <= DONE;
                        done_o  <= 1'b1;
                        whilo_o <= 1'b1;
                        hi_o    <= mul_res[PW-1:DATA_W];
                        lo_o    <= mul_res[DATA_W-1:0];
                        dz_o    <= 1'b0;
                    end
                end
                DIV: begin
                    if (annul_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        rem_q <= rem_nx;
                        a_q   <= quot_nx;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state   <= DONE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            whilo_o <= 1'b1;
                            hi_o    <= rem_fix;
                            lo_o    <= quot_fix;
                            dz_o    <= 1'b0;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE: DONE always lasts one cycle.
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    if (accept) begin
                        uns_q <= op_i[0];
                        cnt_q <= '0;
                        rem_q <= '0;
`ifdef EX_MULDIV_MACC_EN
                        macc_q <= op_i[2];
                        sub_q  <= op_i[1];
                        acc_q  <= {hi_i, lo_i};
`endif
                        if (op_div) begin
                            if (opb_i == '0) begin
                                state   <= DONE;
                                done_o  <= 1'b1;
                                whilo_o <= 1'b1;
                                hi_o    <= opa_i;
                                lo_o    <= '1;
                                dz_o    <= 1'b1;
                            end else begin
                                state  <= DIV;
                                busy_o <= 1'b1;
                                a_q    <= a_mag;
                                b_q    <= b_mag;
                                qneg_q <= sa ^ sb;
                                rneg_q <= sa;
                            end
                        end else begin
                            state  <= MUL;
                            busy_o <= 1'b1;
                            a_q    <= opa_i;
                            b_q    <= opb_i;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Purpose: self-checking bench for ex_muldiv (DATA_W=32) with an expected-result queue.
// Latency: every expected result carries the cycle on which done_o must appear.
// Backpressure: stimulus waits for the expected queue to drain between directed steps.
module tb_ex_muldiv;

    localparam int W = 32;
`ifdef EX_MULDIV_MACC_EN
    localparam bit MACC = 1'b1;
`else
    localparam bit MACC = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start_i;
    logic [2:0]   op_i;
    logic [W-1:0] opa_i;
    logic [W-1:0] opb_i;
    logic [W-1:0] hi_i;
    logic [W-1:0] lo_i;
    logic         annul_i;
    logic         busy_o;
    logic         done_o;
    logic         whilo_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic         dz_o;

    ex_muldiv #(.DATA_W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .op_i    (op_i),
        .opa_i   (opa_i),
        .opb_i   (opb_i),
        .hi_i    (hi_i),
        .lo_i    (lo_i),
        .annul_i (annul_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .whilo_o (whilo_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .dz_o    (dz_o)
    );

    typedef struct {
        int           cyc;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_total = 0;
    int   done_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (busy_o) busy_total++;
        if (done_o || whilo_o) begin
            done_total++;
            chk("whilo_eq_done", whilo_o, done_o);
            chk("done_not_busy", busy_o, 0);
            chk("done_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("hi", hi_o, e.hi);
                chk("lo", lo_o, e.lo);
                chk("dz", dz_o, e.dz);
            end
        end
    end

    // Reference model built on plain wide arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] h, input logic [W-1:0] l);
        exp_t   m;
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        m.dz = 1'b0;
        if (!op[2] && op[1]) begin
            if (b == 0) begin
                m.cyc = 1; m.hi = a; m.lo = '1; m.dz = 1'b1;
            end else begin
                m.cyc = W + 1;
                if (op[0]) begin
                    p = {32'h0, a} / {32'h0, b}; m.lo = p[W-1:0];
                    p = {32'h0, a} % {32'h0, b}; m.hi = p[W-1:0];
                end else begin
                    q = sa / sb; r = sa % sb;
                    m.lo = q[W-1:0]; m.hi = r[W-1:0];
                end
            end
        end else begin
            m.cyc = 2;
            if (op[0]) p = {32'h0, a} * {32'h0, b};
            else       p = sa * sb;
            if (op[2]) p = op[1] ? ({h, l} - p) : ({h, l} + p);
            m.hi = p[63:32];
            m.lo = p[31:0];
        end
        return m;
    endfunction

    // Called #1 after a rising edge; holds start_i for one edge and returns #1 after it.
    task automatic go(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] h, input logic [W-1:0] l);
        op_i = op; opa_i = a; opb_i = b; hi_i = h; lo_i = l; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic run_exp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] h, input logic [W-1:0] l, input int lat,
                           input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
        exp_t x;
        x.cyc = cyc + lat; x.hi = ehi; x.lo = elo; x.dz = edz;
        exp_q.push_back(x);
        go(op, a, b, h, l);
    endtask

    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] h, input logic [W-1:0] l);
        exp_t m;
        m = model(op, a, b, h, l);
        run_exp(op, a, b, h, l, m.cyc, m.hi, m.lo, m.dz);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        logic [W-1:0] hold_hi;
        logic [W-1:0] hold_lo;
        int b0;
        int d0;
        logic [2:0] rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst = 1'b1; start_i = 1'b0; op_i = '0; opa_i = '0; opb_i = '0;
        hi_i = '0; lo_i = '0; annul_i = 1'b0;
        #2;
        chk("reset_ctl", {busy_o, done_o, whilo_o, dz_o}, 0);
        chk("reset_hi", hi_o, 0);
        chk("reset_lo", lo_o, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Signed and unsigned multiply of the same operands.
        run_exp(3'b000, 32'hFFFFFFFE, 32'h00000003, 0, 0, 2, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        drain();
        run_exp(3'b001, 32'hFFFFFFFE, 32'h00000003, 0, 0, 2, 32'h00000002, 32'hFFFFFFFA, 1'b0);
        drain();

        // Signed divide: busy for exactly 32 cycles.
        b0 = busy_total;
        run_exp(3'b010, 32'hFFFFFFF9, 32'h00000002, 0, 0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        drain();
        chk("div_busy_cycles", busy_total - b0, 32);

        // Divide by zero completes one cycle after accept, no busy.
        b0 = busy_total;
        run_exp(3'b011, 32'h00001234, 32'h0, 0, 0, 1, 32'h00001234, 32'hFFFFFFFF, 1'b1);
        drain();
        chk("dz_no_busy", busy_total - b0, 0);

        // Most-negative / -1.
        run_exp(3'b010, 32'h80000000, 32'hFFFFFFFF, 0, 0, 33, 32'h0, 32'h80000000, 1'b0);
        drain();

        // Multiply-accumulate family.
        if (MACC) begin
            run_exp(3'b100, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 2, 32'h00000001, 32'h00000000, 1'b0);
            drain();
            run_exp(3'b110, 32'h1, 32'h1, 32'h0, 32'h0, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
            drain();
        end else begin
            hold_hi = hi_o; hold_lo = lo_o; d0 = done_total;
            go(3'b100, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF);
            chk("madd_off_busy", busy_o, 0);
            go(3'b110, 32'h1, 32'h1, 32'h0, 32'h0);
            chk("msub_off_busy", busy_o, 0);
            repeat (4) @(posedge clk);
            #1;
            chk("macc_off_done", done_total - d0, 0);
            chk("macc_off_hi", hi_o, hold_hi);
            chk("macc_off_lo", lo_o, hold_lo);
        end

        // Annul on DIV cycle 10, then an immediate MULTU.
        hold_hi = hi_o; hold_lo = lo_o; d0 = done_total;
        go(3'b011, 32'd1000, 32'd7, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        chk("div_busy_before_annul", busy_o, 1);
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        chk("annul_busy", busy_o, 0);
        chk("annul_hi_held", hi_o, hold_hi);
        chk("annul_lo_held", lo_o, hold_lo);
        run_exp(3'b001, 32'd5, 32'd7, 0, 0, 2, 32'h0, 32'h23, 1'b0);
        drain();
        chk("annul_single_done", done_total - d0, 1);

        // Start during MUL is ignored; start in the DONE cycle is accepted.
        d0 = done_total;
        run(3'b000, 32'h12345678, 32'h9ABCDEF0, 0, 0);
        chk("mul_busy", busy_o, 1);
        go(3'b011, 32'd99, 32'd3, 0, 0);
        chk("done_cycle_seen", done_o, 1);
        run(3'b001, 32'hDEADBEEF, 32'h00010001, 0, 0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_done_count", done_total - d0, 2);

        // Reset pulsed mid-divide.
        d0 = done_total;
        go(3'b010, 32'd12345, 32'd11, 0, 0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", {busy_o, done_o, whilo_o, dz_o}, 0);
        chk("rst_mid_hi", hi_o, 0);
        chk("rst_mid_lo", lo_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("rst_no_done", done_total - d0, 0);

        // Random operations against the model.
        for (int i = 0; i < 10; i++) begin
            rop = MACC ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 4) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
            if (i == 6) rb = 32'hFFFFFFFF;
            run(rop, ra, rb, $urandom, $urandom);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
